// File: rtl/fir_y_stream_fifo.sv
// ----------------------------------------------------------------------------
// fir_y_stream_fifo
//
// Output buffer between the FIR core's AXI4-Stream master and the downstream
// y consumer. Absorbs consumer back-pressure so the FIR can keep producing one
// y beat per tap sweep. It carries tlast through with the data, and reports
// occupancy, the number of beats sent in the current frame, and the number of
// completed frames.
//
// Ports
//   axis_clk     clock, all logic on the rising edge
//   axis_rst_n   asynchronous active-low reset
//   clr          synchronous flush of FIFO contents and counters
//   s_tvalid     upstream y valid (from FIR sm_tvalid)
//   s_tdata      upstream y data
//   s_tlast      upstream last-of-frame
//   s_tready     ready to accept (to FIR sm_tready)
//   m_tvalid     downstream valid
//   m_tdata      downstream data (0 while empty)
//   m_tlast      downstream last-of-frame (0 while empty)
//   m_tready     downstream ready
//   level        current entry count, 0..pDEPTH
//   sample_cnt   beats sent in the current frame
//   frame_cnt    frames completed (tlast beats sent), wraps
//   frame_done   one-cycle pulse after a tlast beat leaves
// ----------------------------------------------------------------------------
module fir_y_stream_fifo #(
    parameter int pDATA_WIDTH = 32,
    parameter int pDEPTH      = 16,
    parameter int pCNT_WIDTH  = 16
) (
    input  logic                       axis_clk,
    input  logic                       axis_rst_n,
    input  logic                       clr,
    input  logic                       s_tvalid,
    input  logic [pDATA_WIDTH-1:0]     s_tdata,
    input  logic                       s_tlast,
    output logic                       s_tready,
    output logic                       m_tvalid,
    output logic [pDATA_WIDTH-1:0]     m_tdata,
    output logic                       m_tlast,
    input  logic                       m_tready,
    output logic [$clog2(pDEPTH):0]    level,
    output logic [pCNT_WIDTH-1:0]      sample_cnt,
    output logic [pCNT_WIDTH-1:0]      frame_cnt,
    output logic                       frame_done
);

    localparam int pADDR_W = $clog2(pDEPTH);

    localparam logic [pADDR_W:0]     LVL_FULL = (pADDR_W + 1)'(pDEPTH);
    localparam logic [pADDR_W:0]     LVL_ONE  = (pADDR_W + 1)'(1);
    localparam logic [pADDR_W-1:0]   PTR_ONE  = pADDR_W'(1);
    localparam logic [pCNT_WIDTH-1:0] CNT_ONE = pCNT_WIDTH'(1);

    // Each entry stores {tlast, tdata}
    logic [pDATA_WIDTH:0] mem [pDEPTH];

    logic [pADDR_W-1:0] wr_ptr;
    logic [pADDR_W-1:0] rd_ptr;
    logic               push;
    logic               pop;

    // Ready depends on level only: a full FIFO refuses a beat even when a pop
    // happens in the same cycle, which keeps s_tready free of any m_tready path.
    assign s_tready = (level != LVL_FULL);
    assign m_tvalid = (level != '0);

    assign push = s_tvalid & s_tready;
    assign pop  = m_tvalid & m_tready;

    // Show-ahead read; outputs are forced to zero while empty so stale array
    // contents never appear on the bus.
    always_comb begin
        m_tdata = '0;
        m_tlast = 1'b0;
        if (m_tvalid) begin
            m_tdata = mem[rd_ptr][pDATA_WIDTH-1:0];
            m_tlast = mem[rd_ptr][pDATA_WIDTH];
        end
    end

    // Storage array has no reset; only entries below level are ever visible.
    always_ff @(posedge axis_clk) begin
        if (push && !clr) begin
            mem[wr_ptr] <= {s_tlast, s_tdata};
        end
    end

    // Pointers wrap naturally because pDEPTH is a power of two.
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push && !pop) begin
                level <= level + LVL_ONE;
            end else if (pop && !push) begin
                level <= level - LVL_ONE;
            end
        end
    end

    // Frame statistics follow the beats leaving the FIFO, not those entering.
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            sample_cnt <= '0;
            frame_cnt  <= '0;
            frame_done <= 1'b0;
        end else if (clr) begin
            sample_cnt <= '0;
            frame_cnt  <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (pop) begin
                if (m_tlast) begin
                    sample_cnt <= '0;
                    frame_cnt  <= frame_cnt + CNT_ONE;
                    frame_done <= 1'b1;
                end else begin
                    sample_cnt <= sample_cnt + CNT_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_fir_y_stream_fifo.sv
// ----------------------------------------------------------------------------
// tb_fir_y_stream_fifo
//
// Self-checking bench for fir_y_stream_fifo. A queue of {tlast, tdata} beats
// is the reference: its size is the expected level, its head is the expected
// m_* beat, and the frame statistics are tallied from the beats popped off it.
// ----------------------------------------------------------------------------
module tb_fir_y_stream_fifo;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int CW    = 16;

    logic           axis_clk;
    logic           axis_rst_n;
    logic           clr;
    logic           s_tvalid;
    logic [DW-1:0]  s_tdata;
    logic           s_tlast;
    logic           s_tready;
    logic           m_tvalid;
    logic [DW-1:0]  m_tdata;
    logic           m_tlast;
    logic           m_tready;
    logic [4:0]     level;
    logic [CW-1:0]  sample_cnt;
    logic [CW-1:0]  frame_cnt;
    logic           frame_done;

    fir_y_stream_fifo #(
        .pDATA_WIDTH (DW),
        .pDEPTH      (DEPTH),
        .pCNT_WIDTH  (CW)
    ) dut (
        .axis_clk   (axis_clk),
        .axis_rst_n (axis_rst_n),
        .clr        (clr),
        .s_tvalid   (s_tvalid),
        .s_tdata    (s_tdata),
        .s_tlast    (s_tlast),
        .s_tready   (s_tready),
        .m_tvalid   (m_tvalid),
        .m_tdata    (m_tdata),
        .m_tlast    (m_tlast),
        .m_tready   (m_tready),
        .level      (level),
        .sample_cnt (sample_cnt),
        .frame_cnt  (frame_cnt),
        .frame_done (frame_done)
    );

    initial axis_clk = 1'b0;
    always #5 axis_clk = ~axis_clk;

    // Reference state
    logic [DW:0]    ref_q[$];
    logic [CW-1:0]  ref_sample;
    logic [CW-1:0]  ref_frame;
    logic           ref_done;
    int             frame_pulses;

    int vectors;
    int miscompares;

    task automatic model_clear();
        ref_q.delete();
        ref_sample = '0;
        ref_frame  = '0;
        ref_done   = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_output();
        logic [DW:0] head;
        head = (ref_q.size() != 0) ? ref_q[0] : '0;
        check("s_tready",   32'(s_tready),   32'(ref_q.size() != DEPTH));
        check("m_tvalid",   32'(m_tvalid),   32'(ref_q.size() != 0));
        check("m_tdata",    32'(m_tdata),    32'(head[DW-1:0]));
        check("m_tlast",    32'(m_tlast),    32'(head[DW]));
        check("level",      32'(level),      32'(ref_q.size()));
        check("sample_cnt", 32'(sample_cnt), 32'(ref_sample));
        check("frame_cnt",  32'(frame_cnt),  32'(ref_frame));
        check("frame_done", 32'(frame_done), 32'(ref_done));
    endtask

    // One clock cycle: drive inputs just after an edge, check mid-cycle,
    // then advance the reference by what the edge should have done.
    task automatic apply_stimulus(input logic v, input logic [DW-1:0] d, input logic l,
                                  input logic rdy, input logic c, output logic took);
        logic        exp_push;
        logic        exp_pop;
        logic [DW:0] beat;
        s_tvalid = v;
        s_tdata  = d;
        s_tlast  = l;
        m_tready = rdy;
        clr      = c;
        #3;
        check_output();
        exp_push = v && (ref_q.size() < DEPTH);
        exp_pop  = rdy && (ref_q.size() > 0);
        took     = exp_push && !c;
        @(posedge axis_clk);
        #1;
        if (c) begin
            model_clear();
        end else begin
            ref_done = 1'b0;
            if (exp_pop) begin
                beat = ref_q.pop_front();
                if (beat[DW]) begin
                    ref_sample = '0;
                    ref_frame  = ref_frame + 1'b1;
                    ref_done   = 1'b1;
                    frame_pulses++;
                end else begin
                    ref_sample = ref_sample + 1'b1;
                end
            end
            if (exp_push) begin
                ref_q.push_back({l, d});
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic took;
        logic pend;
        logic [DW-1:0] pd;
        logic pl;
        int idx;
        int guard;

        vectors      = 0;
        miscompares  = 0;
        frame_pulses = 0;
        axis_rst_n   = 1'b0;
        clr          = 1'b0;
        s_tvalid     = 1'b0;
        s_tdata      = '0;
        s_tlast      = 1'b0;
        m_tready     = 1'b0;
        model_clear();
        repeat (2) @(posedge axis_clk);
        #3 axis_rst_n = 1'b1;
        @(posedge axis_clk);
        #1;

        // Reset mid-stream: load a few beats, then pull reset between edges
        $display("[TB] reset test");
        for (int i = 0; i < 3; i++) apply_stimulus(1'b1, DW'(32'hA0 + i), 1'b0, 1'b0, 1'b0, took);
        apply_stimulus(1'b0, '0, 1'b0, 1'b1, 1'b0, took);
        axis_rst_n = 1'b0;
        #2;
        model_clear();
        check_output();
        #4 axis_rst_n = 1'b1;
        @(posedge axis_clk);
        #1;
        check_output();

        // Pass-through of one short frame
        $display("[TB] pass-through test");
        apply_stimulus(1'b1, 32'h11, 1'b0, 1'b1, 1'b0, took);
        apply_stimulus(1'b1, 32'h22, 1'b0, 1'b1, 1'b0, took);
        apply_stimulus(1'b1, 32'h33, 1'b1, 1'b1, 1'b0, took);
        for (int i = 0; i < 4; i++) apply_stimulus(1'b0, '0, 1'b0, 1'b1, 1'b0, took);
        check("frame_cnt_after_frame", 32'(frame_cnt), 32'd1);
        check("frame_done_pulses", 32'(frame_pulses), 32'd1);

        // Fill to full, hold the 17th beat, then drain
        $display("[TB] fill test");
        for (int i = 0; i < DEPTH; i++) apply_stimulus(1'b1, DW'(i), 1'b0, 1'b0, 1'b0, took);
        apply_stimulus(1'b1, 32'h100, 1'b1, 1'b0, 1'b0, took);
        check("held_beat_not_taken", 32'(took), 32'd0);
        apply_stimulus(1'b1, 32'h100, 1'b1, 1'b0, 1'b0, took);
        // Full with a pop in the same cycle: pop only, push on the next cycle
        apply_stimulus(1'b1, 32'h100, 1'b1, 1'b1, 1'b0, took);
        check("full_pop_no_push", 32'(took), 32'd0);
        check("level_after_full_pop", 32'(level), 32'd15);
        apply_stimulus(1'b1, 32'h100, 1'b1, 1'b1, 1'b0, took);
        check("push_after_full_pop", 32'(took), 32'd1);
        guard = 0;
        while (ref_q.size() != 0 && guard < 40) begin
            apply_stimulus(1'b0, '0, 1'b0, 1'b1, 1'b0, took);
            guard++;
        end
        check("drain_complete", 32'(ref_q.size()), 32'd0);
        apply_stimulus(1'b0, '0, 1'b0, 1'b1, 1'b0, took);

        // Random traffic: 40 beats with random valid / ready, source holds beats
        $display("[TB] random wrap test");
        idx   = 0;
        pend  = 1'b0;
        pd    = '0;
        pl    = 1'b0;
        guard = 0;
        while ((idx < 40 || ref_q.size() != 0) && guard < 2000) begin
            if (!pend && idx < 40 && ($urandom_range(0, 3) != 0)) begin
                pend = 1'b1;
                pd   = $urandom;
                pl   = ($urandom_range(0, 7) == 0);
            end
            apply_stimulus(pend, pend ? pd : '0, pend ? pl : 1'b0,
                           ($urandom_range(0, 2) != 0), 1'b0, took);
            if (took) begin
                pend = 1'b0;
                idx++;
            end
            guard++;
        end
        check("random_all_beats_sent", 32'(idx), 32'd40);
        check("random_drained", 32'(ref_q.size()), 32'd0);

        // clr with push and pop active at level 5
        $display("[TB] clr test");
        for (int i = 0; i < 5; i++) apply_stimulus(1'b1, DW'(32'h200 + i), (i == 1), 1'b0, 1'b0, took);
        apply_stimulus(1'b0, '0, 1'b0, 1'b1, 1'b0, took);
        apply_stimulus(1'b0, '0, 1'b0, 1'b1, 1'b0, took);
        apply_stimulus(1'b1, 32'h300, 1'b0, 1'b0, 1'b0, took);
        apply_stimulus(1'b1, 32'h301, 1'b0, 1'b0, 1'b0, took);
        check("level_before_clr", 32'(level), 32'd5);
        apply_stimulus(1'b1, 32'h302, 1'b1, 1'b1, 1'b1, took);
        check("level_after_clr", 32'(level), 32'd0);
        check("frame_cnt_after_clr", 32'(frame_cnt), 32'd0);
        apply_stimulus(1'b0, '0, 1'b0, 1'b1, 1'b0, took);
        apply_stimulus(1'b0, '0, 1'b0, 1'b1, 1'b0, took);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
